irq_pending_encoder: RTL and testbench
======================================

// Module: irq_pending_encoder
// PURPOSE
//  Upstream request-capture stage for the 8-to-3 priority encoder. Turns 8 raw request
//  lines into a registered 3-bit index.
//  - Edge-detects the 8 lines and latches them as pending.
//  - Selects the highest-index unmasked pending line.
//  - Presents its index with a valid/ready handshake and clears that line when the
//    consumer accepts it.
//  - Sits between peripheral request lines and the interrupt/dispatch logic.
// PARAMETERS
//  N       8   number of request lines
//  CODE_W  3   index width, = $clog2(N); must match N
// PORTS
//  clk      in   1       single clock, all state changes on its rising edge
//  rst      in   1       synchronous, active-high reset
//  req      in   N       raw request levels; a rising edge is one request event
//  mask     in   N       1 = line eligible for selection; 0 = line latched but not selected
//  code     out  CODE_W  index of presented request (registered)
//  valid    out  1       code is valid (registered)
//  ready    in   1       consumer accepts code when valid & ready at a clk edge ("fire")
//  pending  out  N       current pending register (observation)
//  overrun  out  1       1-cycle pulse: request edge on a line already pending (event lost)
// BEHAVIOUR
//  Reset (rst=1 at a clk edge): req_q=0, pending=0, code=0, valid=0, overrun=0, state=IDLE.
//   Reset has priority over every other event, including a handshake in progress.
//   Because req_q resets to 0, a line held high across reset release counts as an edge
//   on the first post-reset cycle.
//  Edge detect: req_q <= req every cycle; edge = req & ~req_q (combinational).
//  Pending update each cycle: pending <= (pending & ~clr) | edge.
//   clr = onehot(code) when fire, else 0.
//   Same bit cleared and re-edged in one cycle: the edge wins, so the bit stays pending.
//  overrun <= |(edge & pending & ~clr).
//  Selection: sel = highest i with (pending[i] & mask[i]); none = no such i.
//   Selection is combinational over the current registered pending.
//  FSM, 2 states:
//   IDLE:    if !none: code<=sel, valid<=1, ->PRESENT. Else valid=0, code holds.
//   PRESENT: code and valid held stable until fire, regardless of mask changes or new
//            higher-priority edges. On fire: clear pending[code], valid<=0, ->IDLE.
//  Throughput: one code per 2 cycles max, with one mandatory bubble cycle after each fire.
//  Latency: valid rises at the 2nd rising edge after req[i] is first sampled high.
//   Edge k: pending set. Edge k+1: valid set.
//  Masked lines stay pending indefinitely; unmasking one makes it selectable next IDLE.
//  ready while valid=0: ignored, nothing cleared.
//  All lines pending and all masked: valid stays 0 and no overrun is generated until
//   further edges arrive.
// STRUCTURE
//  Shared package irq_pkg:
//   - N, CODE_W constants
//   - typedef state_t {IDLE, PRESENT}
//   - function onehot(code) returning an N-bit one-hot vector
//  Sub-module irq_prio_enc: combinational N->CODE_W highest-index-wins encoder with a
//   'none' flag. Instantiated once on (pending & mask).
//  Top holds req_q, the pending register, the FSM and the output registers.
// TESTING
//  1. rst=1 for 2 cycles with req=8'h00, then release.
//     -> code=0, valid=0, pending=0, overrun=0 during and after reset.
//  2. mask=8'hFF, req 0->8'b00000100 and held, ready=1.
//     -> pending=8'h04 after edge k; valid=1, code=3'd2 after edge k+1;
//        fire clears pending and valid=0 after edge k+2; no re-trigger while held.
//  3. mask=8'hFF, single-cycle pulses on req[3], req[6], req[0] in the same cycle, ready=0.
//     -> code=6 held.
//     Then ready=1 for one cycle -> bubble, then code=3.
//     Then ready=1 for one cycle -> bubble, then code=0.
//     pending ends at 8'h00.
//  4. mask=8'h7F, req[7] and req[1] pulse.
//     -> code=1 presented, pending=8'h80 after accept.
//     Then mask=8'hFF -> code=7 on next IDLE cycle.
//  5. req[5] pulses twice before acceptance.
//     -> overrun=1 for exactly one cycle on the 2nd edge.
//     Also req[5] edge in the same cycle as fire of code=5 -> pending[5] stays 1, no overrun.
//  6. valid=1, code=4, then rst=1 for one cycle with ready=1.
//     -> valid=0, pending=0 next cycle, no clear or overrun side effects.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared constants, FSM state type and helpers for the request-capture stage.
package irq_pkg;

    localparam int unsigned N      = 8;
    localparam int unsigned CODE_W = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    // One-hot vector with only bit 'code' set.
    function automatic logic [N-1:0] onehot(input logic [CODE_W-1:0] code);
        return N'(1) << code;
    endfunction

endpackage : irq_pkg

// File: rtl/irq_pending_encoder_if.sv
// Valid/ready handshake carrying the selected request index.
interface irq_pending_encoder_if
    import irq_pkg::*;
();

    logic [CODE_W-1:0] code;
    logic              valid;
    logic              ready;

    modport master (output code, output valid, input ready);
    modport slave  (input code, input valid, output ready);

endinterface : irq_pending_encoder_if

// File: rtl/irq_prio_enc.sv
// Combinational highest-index-wins encoder with a 'none' flag.
module irq_prio_enc
    import irq_pkg::*;
(
    input  logic [N-1:0]      vec,
    output logic [CODE_W-1:0] sel,
    output logic              none
);

    // Ascending scan so the last (highest) set bit overrides lower ones.
    always_comb begin
        sel  = '0;
        none = 1'b1;
        for (int unsigned i = 0; i < N; i++) begin
            if (vec[i]) begin
                sel  = CODE_W'(i);
                none = 1'b0;
            end
        end
    end

endmodule : irq_prio_enc

// File: rtl/irq_pending_encoder.sv
// Edge-captures request lines as pending and presents the highest unmasked one.
module irq_pending_encoder
    import irq_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N-1:0]            req,
    input  logic [N-1:0]            mask,
    output logic [N-1:0]            pending,
    output logic                    overrun,
    irq_pending_encoder_if.master   bus
);

    state_t            state_q, state_d;
    logic [N-1:0]      req_q;
    logic [N-1:0]      pending_q;
    logic [CODE_W-1:0] code_q, code_d;
    logic              valid_q, valid_d;
    logic              overrun_q;

    logic [N-1:0]      req_edge;
    logic [N-1:0]      clr;
    logic [N-1:0]      pending_d;
    logic              overrun_d;
    logic              fire;
    logic [CODE_W-1:0] sel;
    logic              none;

    irq_prio_enc u_prio_enc (
        .vec  (pending_q & mask),
        .sel  (sel),
        .none (none)
    );

    // Edge detect and pending update; a new edge beats a same-cycle clear.
    always_comb begin
        fire      = valid_q & bus.ready;
        clr       = fire ? onehot(code_q) : '0;
        req_edge  = req & ~req_q;
        pending_d = (pending_q & ~clr) | req_edge;
        overrun_d = |(req_edge & pending_q & ~clr);
    end

    // Next-state and output-register inputs; presented code is frozen until fire.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (!none) begin
                    code_d  = sel;
                    valid_d = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (fire) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture, pending and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q     <= '0;
            pending_q <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            req_q     <= req;
            pending_q <= pending_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.code  = code_q;
    assign bus.valid = valid_q;
    assign pending   = pending_q;
    assign overrun   = overrun_q;

endmodule : irq_pending_encoder

// File: tb/tb_irq_pending_encoder.sv
// Directed bench for irq_pending_encoder.
module tb_irq_pending_encoder;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] mask;
    logic [7:0] pending;
    logic       overrun;

    int tests_run;
    int tests_failed;

    irq_pending_encoder_if bus ();

    irq_pending_encoder dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .mask    (mask),
        .pending (pending),
        .overrun (overrun),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [2:0] code_e, input logic valid_e,
                           input logic [7:0] pend_e, input logic ovr_e);
        chk({tag, ".code"},    32'(bus.code),  32'(code_e));
        chk({tag, ".valid"},   32'(bus.valid), 32'(valid_e));
        chk({tag, ".pending"}, 32'(pending),   32'(pend_e));
        chk({tag, ".overrun"}, 32'(overrun),   32'(ovr_e));
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst       = 1'b1;
        req       = 8'h00;
        mask      = 8'h00;
        bus.ready = 1'b0;

        // 1. reset
        tick(); chk_out("rst0", 3'd0, 1'b0, 8'h00, 1'b0);
        tick(); chk_out("rst1", 3'd0, 1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        tick(); chk_out("post_rst", 3'd0, 1'b0, 8'h00, 1'b0);

        // 2. single held request, consumer always ready
        mask = 8'hFF; bus.ready = 1'b1; req = 8'h04;
        tick(); chk_out("t2_k",   3'd0, 1'b0, 8'h04, 1'b0);
        tick(); chk_out("t2_k1",  3'd2, 1'b1, 8'h04, 1'b0);
        tick(); chk_out("t2_k2",  3'd2, 1'b0, 8'h00, 1'b0);
        tick(); chk_out("t2_hold", 3'd2, 1'b0, 8'h00, 1'b0);
        req = 8'h00;
        tick();

        // 3. three simultaneous pulses, drained in priority order
        bus.ready = 1'b0; req = 8'h49;
        tick(); chk_out("t3_cap", 3'd2, 1'b0, 8'h49, 1'b0);
        req = 8'h00;
        tick(); chk_out("t3_p6",   3'd6, 1'b1, 8'h49, 1'b0);
        tick(); chk_out("t3_p6h",  3'd6, 1'b1, 8'h49, 1'b0);
        bus.ready = 1'b1;
        tick(); chk_out("t3_f6",   3'd6, 1'b0, 8'h09, 1'b0);
        bus.ready = 1'b0;
        tick(); chk_out("t3_p3",   3'd3, 1'b1, 8'h09, 1'b0);
        bus.ready = 1'b1;
        tick(); chk_out("t3_f3",   3'd3, 1'b0, 8'h01, 1'b0);
        bus.ready = 1'b0;
        tick(); chk_out("t3_p0",   3'd0, 1'b1, 8'h01, 1'b0);
        bus.ready = 1'b1;
        tick(); chk_out("t3_f0",   3'd0, 1'b0, 8'h00, 1'b0);
        bus.ready = 1'b0;

        // 4. masked line stays pending until unmasked
        mask = 8'h7F; req = 8'h82;
        tick(); chk_out("t4_cap", 3'd0, 1'b0, 8'h82, 1'b0);
        req = 8'h00;
        tick(); chk_out("t4_p1",  3'd1, 1'b1, 8'h82, 1'b0);
        bus.ready = 1'b1;
        tick(); chk_out("t4_f1",  3'd1, 1'b0, 8'h80, 1'b0);
        bus.ready = 1'b0;
        tick(); chk_out("t4_msk", 3'd1, 1'b0, 8'h80, 1'b0);
        mask = 8'hFF;
        tick(); chk_out("t4_p7",  3'd7, 1'b1, 8'h80, 1'b0);
        bus.ready = 1'b1;
        tick(); chk_out("t4_f7",  3'd7, 1'b0, 8'h00, 1'b0);
        bus.ready = 1'b0;

        // 5. overrun on re-edge, and re-edge coinciding with fire
        req = 8'h20;
        tick(); chk_out("t5_cap",  3'd7, 1'b0, 8'h20, 1'b0);
        req = 8'h00;
        tick(); chk_out("t5_p5",   3'd5, 1'b1, 8'h20, 1'b0);
        req = 8'h20;
        tick(); chk_out("t5_ovr",  3'd5, 1'b1, 8'h20, 1'b1);
        req = 8'h00;
        tick(); chk_out("t5_ovr0", 3'd5, 1'b1, 8'h20, 1'b0);
        req = 8'h20; bus.ready = 1'b1;
        tick(); chk_out("t5_fe",   3'd5, 1'b0, 8'h20, 1'b0);
        req = 8'h00; bus.ready = 1'b0;
        tick(); chk_out("t5_rep",  3'd5, 1'b1, 8'h20, 1'b0);
        bus.ready = 1'b1;
        tick(); chk_out("t5_f",    3'd5, 1'b0, 8'h00, 1'b0);
        bus.ready = 1'b0;

        // 6. reset during a presented handshake
        req = 8'h10;
        tick(); chk_out("t6_cap", 3'd5, 1'b0, 8'h10, 1'b0);
        req = 8'h00;
        tick(); chk_out("t6_p4",  3'd4, 1'b1, 8'h10, 1'b0);
        rst = 1'b1; bus.ready = 1'b1;
        tick(); chk_out("t6_rst", 3'd0, 1'b0, 8'h00, 1'b0);
        rst = 1'b0; bus.ready = 1'b0;
        tick(); chk_out("t6_post", 3'd0, 1'b0, 8'h00, 1'b0);

        // Line held high across reset release counts as an edge.
        rst = 1'b1; req = 8'h01;
        tick(); chk_out("hold_rst", 3'd0, 1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        tick(); chk_out("hold_rel", 3'd0, 1'b0, 8'h01, 1'b0);
        tick(); chk_out("hold_p0",  3'd0, 1'b1, 8'h01, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_irq_pending_encoder
